// File: rtl/sb_stream_arbiter.sv
// Two-input packet-aware stream arbiter with a registered output stage.
// Whole packets are granted round-robin; beats of different packets never interleave.
module sb_stream_arbiter #(
    parameter int DW = 256,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [DW-1:0] in0_data,
    input  logic [31:0]   in0_dest,
    input  logic          in0_last,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in1_data,
    input  logic [31:0]   in1_dest,
    input  logic          in1_last,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [DW-1:0] out_data,
    output logic [31:0]   out_dest,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state, state_next;
    logic   prio, prio_next;
    logic   sel, has_sel, sel_valid, sel_last;
    logic   can_load, accept;

    assign can_load = !out_valid || out_ready;
    assign busy     = (state != IDLE) || out_valid;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    always_comb begin
        sel        = 1'b0;
        has_sel    = 1'b0;
        state_next = state;
        prio_next  = prio;
        case (state)
            LOCK0: begin
                sel     = 1'b0;
                has_sel = 1'b1;
            end
            LOCK1: begin
                sel     = 1'b1;
                has_sel = 1'b1;
            end
            default: begin
                has_sel = in0_valid || in1_valid;
                sel     = (in0_valid && in1_valid) ? prio : in1_valid;
            end
        endcase
        sel_valid = sel ? in1_valid : in0_valid;
        sel_last  = sel ? in1_last  : in0_last;
        in0_ready = can_load && has_sel && !sel && nreset;
        in1_ready = can_load && has_sel &&  sel && nreset;
        accept    = sel_valid && (in0_ready || in1_ready);
        // A last beat releases the lock and hands priority to the other input.
        if (accept) begin
            if (sel_last) begin
                state_next = IDLE;
                prio_next  = ~sel;
            end else begin
                state_next = sel ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel ? in1_data : in0_data;
            out_dest  <= sel ? in1_dest : in0_dest;
            out_last  <= sel_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (accept && sel_last) begin
            if (sel) pkt_cnt1 <= pkt_cnt1 + 1'b1;
            else     pkt_cnt0 <= pkt_cnt0 + 1'b1;
        end
    end

endmodule

// File: tb/tb_sb_stream_arbiter.sv
// Self-checking bench for sb_stream_arbiter: vector table, directed corner cases,
// and a random run checked against per-input packet queues.
module tb_sb_stream_arbiter;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nreset;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic [31:0]   in0_dest, in1_dest, out_dest;
    logic          in0_last, in0_valid, in0_ready;
    logic          in1_last, in1_valid, in1_ready;
    logic          out_last, out_valid, out_ready;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic          busy;

    sb_stream_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .nreset(nreset),
        .in0_data(in0_data), .in0_dest(in0_dest), .in0_last(in0_last),
        .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_dest(in1_dest), .in1_last(in1_last),
        .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    cur_src = -1;
    bit    rand_done = 1'b0;

    typedef struct packed {
        bit       v0, l0, v1, l1, ordy, r0, r1;
        bit [3:0] c0, c1;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? in0_ready : in1_ready;
    endfunction

    task automatic drive(input int p, input logic v, input logic [DW-1:0] d, input logic l);
        if (p == 0) begin
            in0_valid = v; in0_data = d; in0_last = l;
        end else begin
            in1_valid = v; in1_data = d; in1_last = l;
        end
    endtask

    task automatic expect_beat(input int p, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        if (p == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    // Present one beat, wait (bounded) for ready, complete the handshake.
    task automatic send_beat(input int p, input logic [DW-1:0] d, input logic l);
        int n;
        drive(p, 1'b1, d, l);
        expect_beat(p, d, l);
        #1;
        n = 0;
        while (!rdy(p) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check($sformatf("in%0d handshake", p), rdy(p), 1);
        @(posedge clk);
        #1;
        drive(p, 1'b0, d, l);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_last = 1'b0;  in1_last = 1'b0;
        out_ready = 1'b1;
        step();
        nreset = 1'b1;
    endtask

    task automatic rand_driver(input int p, input int npkt);
        int len;
        for (int k = 0; k < npkt; k++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                while ($urandom_range(0, 3) == 0) step();
                send_beat(p, 32'((p << 24) | (k << 8) | b), (b == len - 1));
            end
        end
    endtask

    // Output monitor: checks every accepted output beat against the per-input queues.
    always @(negedge clk) begin : mon
        int    src;
        beat_t e;
        if (!nreset) begin
            exp_q0.delete();
            exp_q1.delete();
            cur_src = -1;
        end else if (out_valid && out_ready) begin
            check("out_dest id", {out_dest[31:1], 1'b0}, 32'hD0);
            src = out_dest[0] ? 1 : 0;
            if (cur_src != -1) check("packet contiguous", src, cur_src);
            check($sformatf("in%0d beat expected", src),
                  (src == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0), 1);
            if ((src == 0 && exp_q0.size() > 0) || (src == 1 && exp_q1.size() > 0)) begin
                e = (src == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("in%0d out_data", src), out_data, e.data);
                check($sformatf("in%0d out_last", src), out_last, e.last);
                cur_src = out_last ? -1 : src;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in0_dest = 32'hD0;
        in1_dest = 32'hD1;
        in0_data = '0;
        in1_data = '0;
        // {v0 l0 v1 l1 ordy r0 r1}, pkt_cnt0, pkt_cnt1 after the edge
        tbl[0]  = {7'b1111110, 4'd1, 4'd0};
        tbl[1]  = {7'b1111101, 4'd1, 4'd1};
        tbl[2]  = {7'b1111110, 4'd2, 4'd1};
        tbl[3]  = {7'b1011101, 4'd2, 4'd2};
        tbl[4]  = {7'b1011110, 4'd2, 4'd2};
        tbl[5]  = {7'b0011110, 4'd2, 4'd2};
        tbl[6]  = {7'b1011010, 4'd2, 4'd2};
        tbl[7]  = {7'b1111000, 4'd2, 4'd2};
        tbl[8]  = {7'b1111110, 4'd3, 4'd2};
        tbl[9]  = {7'b1111101, 4'd3, 4'd3};
        tbl[10] = {7'b1100110, 4'd4, 4'd3};
        tbl[11] = {7'b0011101, 4'd4, 4'd4};
        tbl[12] = {7'b0000100, 4'd4, 4'd4};

        // Reset: readies low while nreset low, outputs cleared.
        nreset = 1'b0;
        out_ready = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_last = 1'b1;  in1_last = 1'b1;
        #1;
        check("reset in0_ready", in0_ready, 0);
        check("reset in1_ready", in1_ready, 0);
        step();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_dest", out_dest, 0);
        check("reset out_last", out_last, 0);
        check("reset pkt_cnt0", pkt_cnt0, 0);
        check("reset pkt_cnt1", pkt_cnt1, 0);
        check("reset busy", busy, 0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        nreset = 1'b1;
        step();

        // Table-driven arbitration vectors.
        for (int i = 0; i < 13; i++) begin
            in0_valid = tbl[i].v0; in0_last = tbl[i].l0; in0_data = 32'(32'hA00 + i);
            in1_valid = tbl[i].v1; in1_last = tbl[i].l1; in1_data = 32'(32'hB00 + i);
            out_ready = tbl[i].ordy;
            if (tbl[i].v0 && tbl[i].r0) expect_beat(0, 32'(32'hA00 + i), tbl[i].l0);
            if (tbl[i].v1 && tbl[i].r1) expect_beat(1, 32'(32'hB00 + i), tbl[i].l1);
            #1;
            check($sformatf("vec%0d in0_ready", i), in0_ready, tbl[i].r0);
            check($sformatf("vec%0d in1_ready", i), in1_ready, tbl[i].r1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pkt_cnt0", i), pkt_cnt0, tbl[i].c0);
            check($sformatf("vec%0d pkt_cnt1", i), pkt_cnt1, tbl[i].c1);
        end
        check("table end busy", busy, 0);
        check("table end out_valid", out_valid, 0);

        // 4-beat in0 packet with in1 waiting.
        do_reset();
        drive(1, 1'b1, 32'h77, 1'b1);
        expect_beat(1, 32'h77, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 32'(32'h10 + k), (k == 3));
            expect_beat(0, 32'(32'h10 + k), (k == 3));
            #1;
            check($sformatf("lock beat%0d in0_ready", k), in0_ready, 1);
            check($sformatf("lock beat%0d in1_ready", k), in1_ready, 0);
            step();
            check($sformatf("lock beat%0d out_data", k), out_data, 32'h10 + k);
        end
        drive(0, 1'b0, '0, 1'b0);
        #1;
        check("after lock in1_ready", in1_ready, 1);
        step();
        check("after lock out_data", out_data, 32'h77);
        check("after lock out_last", out_last, 1);
        drive(1, 1'b0, '0, 1'b0);
        step();
        step();

        // Output stall mid-packet.
        do_reset();
        send_beat(0, 32'h20, 1'b0);
        send_beat(0, 32'h21, 1'b0);
        out_ready = 1'b0;
        drive(0, 1'b1, 32'h22, 1'b0);
        expect_beat(0, 32'h22, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d in0_ready", k), in0_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d out_valid", k), out_valid, 1);
            check($sformatf("stall%0d out_data", k), out_data, 32'h21);
            check($sformatf("stall%0d out_last", k), out_last, 0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall in0_ready", in0_ready, 1);
        step();
        check("unstall out_data", out_data, 32'h22);
        drive(0, 1'b0, '0, 1'b0);
        send_beat(0, 32'h23, 1'b1);
        step();
        step();
        check("stall pkt_cnt0", pkt_cnt0, 1);

        // Counter wrap with CW=4.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            send_beat(1, 32'(32'h300 + k), 1'b1);
            if (k == 15) check("wrap pkt_cnt1 at 16", pkt_cnt1, 0);
        end
        check("wrap pkt_cnt1 at 17", pkt_cnt1, 1);
        check("wrap pkt_cnt0", pkt_cnt0, 0);
        step();
        step();

        // Reset mid-packet, then a fresh in1 packet.
        do_reset();
        drive(1, 1'b1, 32'h55, 1'b1);
        send_beat(0, 32'h30, 1'b0);
        send_beat(0, 32'h31, 1'b0);
        nreset = 1'b0;
        #1;
        check("midreset in0_ready", in0_ready, 0);
        check("midreset in1_ready", in1_ready, 0);
        step();
        nreset = 1'b1;
        check("midreset out_valid", out_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset pkt_cnt0", pkt_cnt0, 0);
        check("midreset pkt_cnt1", pkt_cnt1, 0);
        expect_beat(1, 32'h55, 1'b1);
        #1;
        check("postreset in1_ready", in1_ready, 1);
        step();
        check("postreset out_data", out_data, 32'h55);
        check("postreset out_dest", out_dest, 32'hD1);
        drive(1, 1'b0, '0, 1'b0);
        step();
        step();

        // Random valid and out_ready against per-input packet queues.
        do_reset();
        rand_done = 1'b0;
        fork
            begin
                fork
                    rand_driver(0, 40);
                    rand_driver(1, 40);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 100 && (exp_q0.size() > 0 || exp_q1.size() > 0); n++) step();
        step();
        check("random drain in0 queue", exp_q0.size(), 0);
        check("random drain in1 queue", exp_q1.size(), 0);
        check("random end busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_stream_arbiter.md
SB_STREAM_ARBITER -- requirements
Module: sb_stream_arbiter

Interface
REQ-001 Parameter DW, default 256: width of every data bus.
REQ-002 Parameter CW, default 16: width of each per-input packet counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 nreset  input  1  reset, synchronous and active-low, sampled on posedge clk.
REQ-005 in0_data  input  DW  input 0 beat payload.
REQ-006 in0_dest  input  32  input 0 destination.
REQ-007 in0_last  input  1  input 0 final beat of packet.
REQ-008 in0_valid  input  1  input 0 beat present.
REQ-009 in0_ready  output  1  input 0 beat accepted when valid and ready are both high.
REQ-010 in1_data, in1_dest, in1_last, in1_valid, in1_ready SHALL mirror in0_* in widths and directions.
REQ-011 out_data  output  DW  registered output payload.
REQ-012 out_dest  output  32  registered output destination.
REQ-013 out_last  output  1  registered output last flag.
REQ-014 out_valid  output  1  registered output beat present.
REQ-015 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-016 pkt_cnt0  output  CW  count of complete packets forwarded from input 0.
REQ-017 pkt_cnt1  output  CW  count of complete packets forwarded from input 1.
REQ-018 busy  output  1  high when state is not IDLE, or out_valid is high.

Function
REQ-019 The block SHALL merge two valid/ready streams onto one output, never interleaving beats of different packets.
REQ-020 FSM states SHALL be IDLE, LOCK0 and LOCK1, plus a 1-bit round-robin pointer prio.
REQ-021 Define can_load = !out_valid || out_ready; an input beat SHALL be accepted only when can_load is high.
REQ-022 In IDLE, sel SHALL be the input whose valid is high; if both are high, sel = prio; if neither is high, there is no selection.
REQ-023 In LOCKi, sel SHALL be i regardless of the other input's valid.
REQ-024 ini_ready SHALL be can_load && (sel==i) && nreset; the unselected input's ready SHALL be 0.
REQ-025 On acceptance from input i, out_data, out_dest and out_last SHALL load that beat on the same edge, and out_valid SHALL be set to 1.
REQ-026 Latency SHALL be 1 cycle from input handshake to out_valid; sustained throughput SHALL be 1 beat per cycle while out_ready is held high.
REQ-027 When out_valid && out_ready and there is no new acceptance, out_valid SHALL clear to 0.
REQ-028 While out_valid && !out_ready, all out_* SHALL hold their values.
REQ-029 Accepting a beat with last=0 from input i SHALL move the FSM from IDLE to LOCKi, or keep it in LOCKi.
REQ-030 Accepting a beat with last=1 from input i SHALL move the FSM to IDLE, set prio to the other input, and increment pkt_cnti by 1.
REQ-031 A single-beat packet (last=1 accepted in IDLE) SHALL leave the FSM in IDLE and SHALL flip prio to the other input.
REQ-032 pkt_cnti SHALL wrap from 2^CW-1 to 0 with no saturation flag.
REQ-033 In LOCKi with ini_valid low, the FSM SHALL hold LOCKi and the other input SHALL stay stalled; there is no timeout.

Reset
REQ-034 When nreset is low at posedge clk, the block SHALL set: state IDLE, prio 0, out_valid 0, out_data 0, out_dest 0, out_last 0, pkt_cnt0 0, pkt_cnt1 0.
REQ-035 A reset asserted mid-packet or with a held output beat SHALL discard that beat and packet state; no partial-packet recovery is provided.
REQ-036 in0_ready and in1_ready SHALL be 0 while nreset is low.

Verification
REQ-037 Both inputs send a 1-beat packet every cycle, out_ready=1 -> output alternates in0, in1, in0, ...; in0 goes first after reset; pkt_cnt0 and pkt_cnt1 each advance by 1 every 2 cycles.
REQ-038 in0 sends a 4-beat packet (data 0x10..0x13) while in1_valid is held high -> all four in0 beats are output consecutively, then in1's beat; in1_ready stays 0 until the in0 last beat is accepted.
REQ-039 Apply out_ready=0 for 3 cycles mid-packet -> out_data and out_last stay stable; no input beat is accepted; no beat is lost or duplicated after out_ready returns to 1.
REQ-040 Forward 2^CW+1 single-beat packets from in1 with CW=4 -> pkt_cnt1 reads 1.
REQ-041 Pull nreset low for 1 cycle after the 2nd beat of a 4-beat in0 packet -> next cycle out_valid=0, state IDLE, counters 0; a fresh in1 packet is then granted immediately.
REQ-042 Compare the output against a scoreboard of per-input packet queues under random valid and out_ready -> every packet appears contiguous and in per-input order, and no beat is dropped.
